// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready inter-stage register with flush, optional skid entry and stall counter
//   CLK, RST            clock, async active-high reset
//   flush               squash every held entry (ctrl zeroed, data kept)
//   in_valid/in_ready   upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready downstream handshake, out_ctrl/out_data head payload
//   stall_clr/stall_cnt saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic              main_valid, skid_valid, in_xfer, out_xfer;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    // skid_valid is a flop, so in skid mode in_ready has no combinational path from out_ready
    always_comb begin
        in_ready  = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = main_valid && out_ready;
        out_valid = main_valid;
        out_ctrl  = main_valid ? main_ctrl : '0;
        out_data  = main_data;
    end

    // Without skid mode in_ready blocks any input that would need the skid slot, so it never fills
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else begin
            if (out_xfer && skid_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (in_xfer && (!main_valid || out_xfer)) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else if (out_xfer) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
            if (in_xfer && main_valid && !out_xfer) begin
                skid_valid <= 1'b1;
                skid_ctrl  <= in_ctrl;
                skid_data  <= in_data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (main_valid && !out_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: checks SKID=0 (k=0) and SKID=1 (k=1) instances against a list-based reference model
module tb_pipe_stage_reg;
    logic        CLK = 1'b0;
    logic        RST;
    logic        flush[2], in_valid[2], out_ready[2], stall_clr[2];
    logic [5:0]  in_ctrl[2];
    logic [31:0] in_data[2];
    logic        in_ready[2], out_valid[2];
    logic [5:0]  out_ctrl[2];
    logic [31:0] out_data[2];
    logic [3:0]  stall_cnt[2];

    int vectors = 0, miscompares = 0;

    // reference model: ordered list of held {ctrl,data} entries, entry count, stall count
    logic [37:0] mq[2][2];
    int          mn[2], mcnt[2];

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(0), .CNT_W(4)) u0 (
        .CLK(CLK), .RST(RST), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ctrl(out_ctrl[0]), .out_data(out_data[0]), .stall_clr(stall_clr[0]), .stall_cnt(stall_cnt[0]));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(1), .CNT_W(4)) u1 (
        .CLK(CLK), .RST(RST), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ctrl(out_ctrl[1]), .out_data(out_data[1]), .stall_clr(stall_clr[1]), .stall_cnt(stall_cnt[1]));

    // single register: room if empty or head leaves; skid mode: room while fewer than two held
    function automatic logic exp_rdy(int k);
        return (k == 0) ? (mn[0] == 0 || out_ready[0]) : (mn[1] < 2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0;
            mcnt[k] = 0;
        end
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            flush[k] = 0; in_valid[k] = 0; out_ready[k] = 0; stall_clr[k] = 0;
            in_ctrl[k] = '0; in_data[k] = '0;
        end
    endtask

    task automatic tick();
        logic ai[2], ao[2], st[2];
        for (int k = 0; k < 2; k++) begin
            ai[k] = in_valid[k] && exp_rdy(k);
            ao[k] = mn[k] > 0 && out_ready[k];
            st[k] = mn[k] > 0 && !out_ready[k];
        end
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = stall_clr[k] ? 0 : (st[k] && mcnt[k] < 15) ? mcnt[k] + 1 : mcnt[k];
            if (flush[k]) mn[k] = 0;
            else begin
                if (ao[k]) begin
                    mq[k][0] = mq[k][1];
                    mn[k]--;
                end
                if (ai[k]) begin
                    mq[k][mn[k]] = {in_ctrl[k], in_data[k]};
                    mn[k]++;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1;
        idle();
        model_reset();
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_valid k=%0d got %b exp 0", k, out_valid[k]); end
            vectors++; if (out_ctrl[k] !== 6'h0) begin miscompares++; $display("FAIL reset_ctrl k=%0d got %h exp 0", k, out_ctrl[k]); end
            vectors++; if (out_data[k] !== 32'h0) begin miscompares++; $display("FAIL reset_data k=%0d got %h exp 0", k, out_data[k]); end
            vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL reset_ready k=%0d got %b exp 1", k, in_ready[k]); end
            vectors++; if (stall_cnt[k] !== 4'h0) begin miscompares++; $display("FAIL reset_cnt k=%0d got %0d exp 0", k, stall_cnt[k]); end
        end
        RST = 0;
        @(negedge CLK);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k] = (i < 8); in_ctrl[k] = 6'h2A; in_data[k] = 32'h1000 + i; out_ready[k] = 1;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL stream_ready k=%0d i=%0d got %b exp 1", k, i, in_ready[k]); end
                vectors++; if (out_valid[k] !== (i >= 1 && i <= 8)) begin miscompares++; $display("FAIL stream_valid k=%0d i=%0d got %b exp %b", k, i, out_valid[k], (i >= 1 && i <= 8)); end
                if (i >= 1 && i <= 8) begin
                    vectors++; if (out_data[k] !== 32'h1000 + i - 1) begin miscompares++; $display("FAIL stream_data k=%0d i=%0d got %h exp %h", k, i, out_data[k], 32'h1000 + i - 1); end
                    vectors++; if (out_ctrl[k] !== 6'h2A) begin miscompares++; $display("FAIL stream_ctrl k=%0d i=%0d got %h exp 2a", k, i, out_ctrl[k]); end
                end else begin
                    vectors++; if (out_ctrl[k] !== 6'h0) begin miscompares++; $display("FAIL stream_bubble_ctrl k=%0d i=%0d got %h exp 0", k, i, out_ctrl[k]); end
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_backpressure();
        int          src[2], ns[2];
        logic [31:0] seen[2][4];
        idle();
        for (int k = 0; k < 2; k++) begin stall_clr[k] = 1; src[k] = 0; ns[k] = 0; end
        tick();
        for (int c = 0; c < 9; c++) begin
            for (int k = 0; k < 2; k++) begin
                stall_clr[k] = 0;
                out_ready[k] = !(c >= 1 && c <= 3);
                in_valid[k] = src[k] < 3;
                in_data[k] = 32'hA0 + src[k];
                in_ctrl[k] = 6'(src[k] * 5 + 1);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k] && out_ready[k] && ns[k] < 4) begin
                    seen[k][ns[k]] = out_data[k];
                    ns[k]++;
                end
                if (in_valid[k] && exp_rdy(k)) src[k]++;
            end
            if (c == 2) begin
                vectors++; if (in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL bp_skid_full_ready got %b exp 0", in_ready[1]); end
                vectors++; if (out_data[1] !== 32'hA0) begin miscompares++; $display("FAIL bp_head got %h exp a0", out_data[1]); end
            end
            if (c == 4)
                for (int k = 0; k < 2; k++) begin
                    vectors++; if (stall_cnt[k] !== 4'd3) begin miscompares++; $display("FAIL bp_stall_cnt k=%0d got %0d exp 3", k, stall_cnt[k]); end
                end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            vectors++; if (ns[k] !== 3) begin miscompares++; $display("FAIL bp_count k=%0d got %0d exp 3", k, ns[k]); end
            for (int j = 0; j < 3 && j < ns[k]; j++) begin
                vectors++; if (seen[k][j] !== 32'hA0 + j) begin miscompares++; $display("FAIL bp_order k=%0d j=%0d got %h exp %h", k, j, seen[k][j], 32'hA0 + j); end
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 2; k++) begin in_valid[k] = 1; in_data[k] = 32'hB0; in_ctrl[k] = 6'h11; out_ready[k] = 0; end
        tick();
        for (int k = 0; k < 2; k++) begin in_data[k] = 32'hB1; in_ctrl[k] = 6'h12; out_ready[k] = 1; end
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL simul_ready k=%0d got %b exp 1", k, in_ready[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_data[k] !== 32'hB1 || out_valid[k] !== 1'b1) begin miscompares++; $display("FAIL simul_replace k=%0d got %b/%h exp 1/b1", k, out_valid[k], out_data[k]); end
        end
        idle();
        for (int k = 0; k < 2; k++) out_ready[k] = 1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin in_valid[k] = 1; in_data[k] = 32'hC0; in_ctrl[k] = 6'h21; out_ready[k] = 0; end
        tick();
        for (int k = 0; k < 2; k++) begin in_data[k] = 32'hC1; in_ctrl[k] = 6'h22; end
        tick();
        vectors++; if (in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL flush_setup_full got %b exp 0", in_ready[1]); end
        for (int k = 0; k < 2; k++) begin flush[k] = 1; in_data[k] = 32'hFF; in_ctrl[k] = 6'h3F; end
        tick();
        for (int k = 0; k < 2; k++) begin flush[k] = 0; in_data[k] = 32'hD0; in_ctrl[k] = 6'h05; out_ready[k] = 1; end
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL flush_valid k=%0d got %b exp 0", k, out_valid[k]); end
            vectors++; if (out_ctrl[k] !== 6'h0) begin miscompares++; $display("FAIL flush_ctrl k=%0d got %h exp 0", k, out_ctrl[k]); end
            vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL flush_ready k=%0d got %b exp 1", k, in_ready[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) in_valid[k] = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b1 || out_data[k] !== 32'hD0 || out_ctrl[k] !== 6'h05) begin miscompares++; $display("FAIL flush_next k=%0d got %b/%h/%h exp 1/d0/05", k, out_valid[k], out_data[k], out_ctrl[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL flush_ghost k=%0d got %b/%h exp empty", k, out_valid[k], out_data[k]); end
        end
        idle();
    endtask

    task automatic test_counter();
        for (int k = 0; k < 2; k++) begin stall_clr[k] = 1; in_valid[k] = 1; in_data[k] = 32'hE0; in_ctrl[k] = 6'h01; end
        tick();
        for (int k = 0; k < 2; k++) begin stall_clr[k] = 0; in_valid[k] = 0; end
        repeat (20) tick();
        for (int k = 0; k < 2; k++) begin
            vectors++; if (stall_cnt[k] !== 4'd15) begin miscompares++; $display("FAIL cnt_saturate k=%0d got %0d exp 15", k, stall_cnt[k]); end
            stall_clr[k] = 1;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            stall_clr[k] = 0;
            vectors++; if (stall_cnt[k] !== 4'd0) begin miscompares++; $display("FAIL cnt_clear k=%0d got %0d exp 0", k, stall_cnt[k]); end
            out_ready[k] = 1;
        end
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin in_valid[k] = 1; in_data[k] = 32'hF0; in_ctrl[k] = 6'h09; out_ready[k] = 0; end
        repeat (3) tick();
        idle();
        #2 RST = 1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b0) begin miscompares++; $display("FAIL arst_valid k=%0d got %b exp 0", k, out_valid[k]); end
            vectors++; if (stall_cnt[k] !== 4'd0) begin miscompares++; $display("FAIL arst_cnt k=%0d got %0d exp 0", k, stall_cnt[k]); end
            vectors++; if (in_ready[k] !== 1'b1) begin miscompares++; $display("FAIL arst_ready k=%0d got %b exp 1", k, in_ready[k]); end
        end
        #1 RST = 0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            vectors++; if (out_valid[k] !== 1'b0 || out_ctrl[k] !== 6'h0) begin miscompares++; $display("FAIL arst_after k=%0d got %b/%h exp 0/0", k, out_valid[k], out_ctrl[k]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k] = ($urandom_range(3) != 0);
                out_ready[k] = ($urandom_range(2) != 0);
                flush[k] = ($urandom_range(19) == 0);
                stall_clr[k] = ($urandom_range(24) == 0);
                in_ctrl[k] = 6'($urandom);
                in_data[k] = $urandom;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++; if (in_ready[k] !== exp_rdy(k)) begin miscompares++; $display("FAIL rnd_ready k=%0d i=%0d got %b exp %b", k, i, in_ready[k], exp_rdy(k)); end
                vectors++; if (out_valid[k] !== (mn[k] > 0)) begin miscompares++; $display("FAIL rnd_valid k=%0d i=%0d got %b exp %b", k, i, out_valid[k], mn[k] > 0); end
                vectors++; if (out_ctrl[k] !== (mn[k] > 0 ? mq[k][0][37:32] : 6'h0)) begin miscompares++; $display("FAIL rnd_ctrl k=%0d i=%0d got %h exp %h", k, i, out_ctrl[k], mn[k] > 0 ? mq[k][0][37:32] : 6'h0); end
                if (mn[k] > 0) begin
                    vectors++; if (out_data[k] !== mq[k][0][31:0]) begin miscompares++; $display("FAIL rnd_data k=%0d i=%0d got %h exp %h", k, i, out_data[k], mq[k][0][31:0]); end
                end
                vectors++; if (stall_cnt[k] !== 4'(mcnt[k])) begin miscompares++; $display("FAIL rnd_cnt k=%0d i=%0d got %0d exp %0d", k, i, stall_cnt[k], mcnt[k]); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_counter();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
